// File: rtl/twiddle_fetch_pkg.sv
// Shared types and helpers for the twiddle sequencer: default widths, the
// stage/last tag that rides alongside each ROM read, and the address rule.
package twiddle_fetch_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FFT_LOG2N  = 5;
    localparam int TW_ADDR_WIDTH  = 4;
    localparam int STAGE_WIDTH    = 3;
    localparam int K_WIDTH        = 5;

    typedef struct packed {
        logic [STAGE_WIDTH-1:0] stage;
        logic                   last;
    } tw_tag_t;

    // rom_addr = (k & ((N/2 >> s) - 1)) << s, truncated to the ROM index width
    function automatic logic [TW_ADDR_WIDTH-1:0] tw_addr(
        input logic [K_WIDTH-1:0]     k,
        input logic [STAGE_WIDTH-1:0] s,
        input int                     log2n
    );
        logic [31:0] half;
        logic [31:0] mask;
        half = 32'd1 << (log2n - 1);
        mask = (half >> s) - 32'd1;
        return TW_ADDR_WIDTH'(({27'd0, k} & mask) << s);
    endfunction

endpackage

// File: rtl/twiddle_fifo.sv
// Small synchronous FIFO buffering ROM returns ahead of the PE handshake.
// The caller guarantees no push when full and no pop when empty.
module twiddle_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [$clog2(DEPTH):0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: rtl/twiddle_fetch.sv
// Twiddle sequencer: walks (stage, butterfly) pairs, reads the 2-cycle ROM under
// a credit limit and streams factors to the PE. TWIDDLE_CONJ_EN selects conj(W).
module twiddle_fetch
    import twiddle_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FFT_LOG2N  = DEF_FFT_LOG2N,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      rom_en,
    output logic [TW_ADDR_WIDTH-1:0]  rom_addr,
    input  logic [2*DATA_WIDTH-1:0]   rom_data,
    output logic                      tw_valid,
    input  logic                      tw_ready,
    output logic [2*DATA_WIDTH-1:0]   tw_data,
    output logic [STAGE_WIDTH-1:0]    tw_stage,
    output logic                      tw_last,
    output logic [1:0]                state_dbg
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int HALF   = (1 << FFT_LOG2N) / 2;
    localparam int FIFO_W = 2*DATA_WIDTH + 4;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [K_WIDTH-1:0]     LAST_K = K_WIDTH'(HALF - 1);
    localparam logic [STAGE_WIDTH-1:0] LAST_S = STAGE_WIDTH'(FFT_LOG2N - 1);

    state_e                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [K_WIDTH-1:0]      k_q, k_d;
    logic [STAGE_WIDTH-1:0]  s_q, s_d;
    logic [1:0]              vld_sr_q, vld_sr_d;
    tw_tag_t                 tag_sr_q [2];
    tw_tag_t                 tag_sr_d [2];

    logic [1:0]              inflight;
    logic                    credit_ok;
    logic                    issue_last;
    logic                    pop;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [FIFO_W-1:0]       fifo_wdata;
    logic [FIFO_W-1:0]       fifo_head;
    logic [DATA_WIDTH-1:0]   w_imag;

    // PE handshake: tw_data/tw_stage/tw_last are held while tw_valid && !tw_ready; a beat moves on tw_valid && tw_ready.
    assign inflight   = {1'b0, vld_sr_q[0]} + {1'b0, vld_sr_q[1]};
    assign credit_ok  = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign rom_en     = (state_q == ST_ISSUE) && credit_ok;
    assign rom_addr   = tw_addr(k_q, s_q, FFT_LOG2N);
    assign issue_last = (k_q == LAST_K) && (s_q == LAST_S);
    assign tw_valid   = !fifo_empty;
    assign pop        = tw_valid && tw_ready;

    always_comb begin
`ifdef TWIDDLE_CONJ_EN
        // Negating the most-negative value would wrap, so it saturates instead.
        if (rom_data[DATA_WIDTH-1:0] == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            w_imag = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            w_imag = -rom_data[DATA_WIDTH-1:0];
        end
`else
        w_imag = rom_data[DATA_WIDTH-1:0];
`endif
    end

    assign fifo_wdata = {rom_data[2*DATA_WIDTH-1:DATA_WIDTH], w_imag, tag_sr_q[1]};

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        s_d         = s_q;
        vld_sr_d    = {vld_sr_q[0], rom_en};
        tag_sr_d[1] = tag_sr_q[0];
        tag_sr_d[0] = '{stage: s_q, last: issue_last};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    k_d     = '0;
                    s_d     = '0;
                end
            end
            ST_ISSUE: begin
                if (rom_en) begin
                    if (k_q == LAST_K) begin
                        k_d = '0;
                        if (s_q == LAST_S) begin
                            s_d     = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            s_d = s_q + 1'b1;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_head[0]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            k_q         <= '0;
            s_q         <= '0;
            vld_sr_q    <= '0;
            tag_sr_q[0] <= '0;
            tag_sr_q[1] <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            k_q         <= k_d;
            s_q         <= s_d;
            vld_sr_q    <= vld_sr_d;
            tag_sr_q[0] <= tag_sr_d[0];
            tag_sr_q[1] <= tag_sr_d[1];
        end
    end

    twiddle_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_sr_q[1]),
        .push_data (fifo_wdata),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign tw_data   = fifo_head[FIFO_W-1:4];
    assign tw_stage  = fifo_head[3:1];
    assign tw_last   = fifo_head[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_twiddle_fetch.sv
// Bench for twiddle_fetch: 2-cycle ROM model, expected-beat scoreboard, and
// frame scenarios for free-run, back-pressure, random ready and reset.
module tb_twiddle_fetch;

  localparam int DW = 16;
  localparam int EW = 2*DW + 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          rom_en;
  logic [3:0]    rom_addr;
  logic [2*DW-1:0] rom_data;
  logic          tw_valid;
  logic          tw_ready;
  logic [2*DW-1:0] tw_data;
  logic [2:0]    tw_stage;
  logic          tw_last;
  logic [1:0]    state_dbg;

  twiddle_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .tw_valid  (tw_valid),
    .tw_ready  (tw_ready),
    .tw_data   (tw_data),
    .tw_stage  (tw_stage),
    .tw_last   (tw_last),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [3:0] a);
    case (a)
      4'd0:    return 32'h0001_0000;
      4'd1:    return 32'h0002_0004;
      4'd2:    return 32'h1234_8000;
      default: return {8'h40, 4'h0, a, 4'ha, a, 8'h21};
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef TWIDDLE_CONJ_EN
    logic [15:0] im;
    im = w[15:0];
    if (im == 16'h8000) return {w[31:16], 16'h7fff};
    return {w[31:16], (~im) + 16'd1};
`else
    return w;
`endif
  endfunction

  function automatic logic [3:0] exp_addr(input int k, input int s);
    int mask;
    mask = (16 >> s) - 1;
    return 4'(((k & mask) << s) & 15);
  endfunction

  // 2-cycle ROM; garbage when not enabled so stray captures are visible
  logic [31:0] rom_p1;
  always @(posedge clk) begin
    rom_p1   <= rom_en ? rom_word(rom_addr) : 32'hdead_beef;
    rom_data <= rom_p1;
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [3:0]    exp_addr_q[$];

  int cyc = 0;
  int t_start, first_en_cyc, first_valid_cyc, first_beat_cyc, last_beat_cyc;
  int tlast_cyc, done_cyc, beats, issued, done_cnt;
  logic [31:0] beat_word [0:80];
  logic          hold_pending = 1'b0;
  logic [EW-1:0] held;
  logic          rand_run = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rom_en) begin
        issued++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        check("addr_q_nonempty", 64'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) check("rom_addr", rom_addr, exp_addr_q.pop_front());
      end
      if (hold_pending) begin
        check("hold_valid", tw_valid, 1);
        check("hold_data", {tw_data, tw_stage, tw_last}, held);
      end
      hold_pending = tw_valid && !tw_ready;
      held = {tw_data, tw_stage, tw_last};
      if (tw_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (tw_valid && tw_ready) begin
        beats++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        if (beats <= 80) beat_word[beats] = tw_data;
        if (tw_last) tlast_cyc = cyc;
        check("exp_q_nonempty", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("beat", {tw_data, tw_stage, tw_last}, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      hold_pending = 1'b0;
    end
    cyc++;
  end

  // driver tasks
  task automatic begin_frame();
    beats = 0; issued = 0; done_cnt = 0;
    first_en_cyc = -1; first_valid_cyc = -1; first_beat_cyc = -1;
    last_beat_cyc = -1; tlast_cyc = -1; done_cyc = -1;
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < 16; k++) begin
        logic [3:0] a;
        a = exp_addr(k, s);
        exp_addr_q.push_back(a);
        exp_q.push_back({exp_word(rom_word(a)), 3'(s), (s == 4 && k == 15)});
      end
    end
  endtask

  task automatic drive_start();
    @(posedge clk); #1 start = 1'b1;
    t_start = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", 64'(done_cnt != 0), 1);
  endtask

  task automatic wait_beats(input int nb, input int budget);
    int n = 0;
    while (beats < nb && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("beats_reached", 64'(beats >= nb), 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_rom_en"},   rom_en, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_tw_valid"}, tw_valid, 0);
    check({tag, "_tw_data"},  tw_data, 0);
    check({tag, "_tw_stage"}, tw_stage, 0);
    check({tag, "_tw_last"},  tw_last, 0);
    check({tag, "_state"},    state_dbg, 0);
  endtask

  // called #2 after the edge that ends the done cycle
  task automatic frame_end(input string tag);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_beats"}, 64'(beats), 80);
    check({tag, "_done_cnt"}, 64'(done_cnt), 1);
    check({tag, "_done_ofs"}, 64'(done_cyc - tlast_cyc), 1);
    check({tag, "_exp_left"}, 64'(exp_q.size()), 0);
    check({tag, "_addr_left"}, 64'(exp_addr_q.size()), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tw_ready = 1'b0;
    begin_frame();
    exp_q.delete(); exp_addr_q.delete();
    repeat (3) @(posedge clk);
    #2 check_idle("reset");
    rst = 1'b0;

    // free-running frame
    tw_ready = 1'b1;
    begin_frame();
    drive_start();
    wait_done(400);
    #2 frame_end("free");
    check("free_first_en", 64'(first_en_cyc - t_start), 1);
    check("free_first_valid", 64'(first_valid_cyc - t_start), 4);
    check("free_gapless", 64'(last_beat_cyc - first_beat_cyc), 79);
    check("free_issued", 64'(issued), 80);
    check("free_beat1", beat_word[1], 32'h0001_0000);
`ifdef TWIDDLE_CONJ_EN
    check("conj_beat2", beat_word[2], 32'h0002_fffc);
    check("conj_beat3", beat_word[3], 32'h1234_7fff);
`else
    check("pass_beat2", beat_word[2], 32'h0002_0004);
    check("pass_beat3", beat_word[3], 32'h1234_8000);
`endif

    // back-pressure for 10 cycles after beat 3, plus a start while busy
    repeat (3) @(posedge clk);
    begin_frame();
    drive_start();
    wait_beats(3, 100);
    #1 tw_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 check("bp_rom_en_off", rom_en, 0);
    check("bp_issued", 64'(issued), 7);
    check("bp_busy", busy, 1);
    @(posedge clk); #1 tw_ready = 1'b1;
    wait_done(400);
    #2 frame_end("bp");
    repeat (20) @(posedge clk);
    #2 check("bp_no_restart", 64'(issued), 80);
    check("bp_idle_busy", busy, 0);

    // random ready
    begin_frame();
    rand_run = 1'b1;
    fork
      begin
        while (rand_run) begin
          @(posedge clk); #1;
          if (rand_run) tw_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    drive_start();
    wait_done(2000);
    rand_run = 1'b0;
    #2 frame_end("rand");
    tw_ready = 1'b1;
    repeat (3) @(posedge clk);

    // reset at beat 40, then replay from beat 1
    begin_frame();
    drive_start();
    wait_beats(40, 200);
    #1 rst = 1'b1;
    exp_q.delete(); exp_addr_q.delete();
    @(posedge clk);
    #2 check_idle("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    begin_frame();
    drive_start();
    wait_done(400);
    #2 frame_end("replay");
    check("replay_first_valid", 64'(first_valid_cyc - t_start), 4);
    check("replay_beat1", beat_word[1], exp_word(32'h0001_0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/twiddle_fetch.md
# twiddle_fetch

Twiddle-factor sequencer and reader for the PE array FFT datapath. On `start` it walks every (stage, butterfly) pair of an N-point radix-2 DIF FFT and issues the matching twiddle address to the twiddle ROM. It absorbs the ROM's fixed 2-cycle read latency and buffers returned words in a small FIFO. It then streams twiddles to the butterfly PE over a valid/ready handshake, so PE back-pressure never drops or duplicates a factor.

## Interface
Parameters:
- `DATA_WIDTH`, 16 (from `parameters.vh`): width of one real or imag component; a twiddle is `2*DATA_WIDTH`.
- `FFT_LOG2N`, 5: log2 of FFT size; legal 1..5, because the ROM address is 4 bits.
- `FIFO_DEPTH`, 4: output buffer depth, power of two, ≥ 3.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a frame; ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` through the cycle of `done`.
- `done` out 1: one-cycle pulse after the last twiddle handshake.
- `rom_en` out 1: ROM read enable.
- `rom_addr` out 4: ROM twiddle index.
- `rom_data` in `2*DATA_WIDTH`: ROM output, valid 2 cycles after `rom_en`.
- `tw_valid` out 1: twiddle available.
- `tw_ready` in 1: PE accepts the twiddle.
- `tw_data` out `2*DATA_WIDTH`: {real[hi], imag[lo]}.
- `tw_stage` out 3: FFT stage of the current `tw_data`.
- `tw_last` out 1: marks the final twiddle of the frame.

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE on `start`.
  - ISSUE → DRAIN after the last address is issued.
  - DRAIN → DONE on the final `tw_valid && tw_ready`.
  - DONE → IDLE after one cycle; `done` is high in DONE.
- Issue counters: stage `s` runs 0..FFT_LOG2N-1 (outer loop); butterfly `k` runs 0..N/2-1 (inner loop).
- Address rule: `rom_addr = (k & ((N/2 >> s) - 1)) << s`, truncated to 4 bits.
- Frame length is FFT_LOG2N·N/2 twiddles; the default is 80.
- Credit rule: `rom_en` is asserted in ISSUE only when `fifo_count + inflight < FIFO_DEPTH`.
  - `inflight` counts ROM reads issued but not yet returned, range 0..2.
  - Counters advance only on cycles with `rom_en` high.
- A 2-bit valid shift register tracks in-flight reads. When its tap is set, `rom_data` is written to the FIFO together with its stage and last tag.
  - Stage/last tags travel alongside in a matching 2-deep shift register.
- The FIFO head drives `tw_data`, `tw_stage` and `tw_last`. `tw_valid` is high when the FIFO is not empty.
- The FIFO pops on `tw_valid && tw_ready`. A simultaneous push and pop leaves the count unchanged. Full and empty states are never overrun, by construction of the credit rule.
- A `start` received in any state other than IDLE is ignored.
- Reset in any state returns the block to IDLE:
  - FIFO, counters and in-flight shift register are cleared.
  - ROM returns still outstanding are discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_en`=0, `rom_addr`=0, `tw_valid`=0, `tw_data`=0, `tw_stage`=0, `tw_last`=0.
- `start` sampled high in cycle 0 → first `rom_en` in cycle 1 → `rom_data` captured in cycle 3 → `tw_valid` high in cycle 4.
- With `tw_ready` held high, steady-state throughput is 1 twiddle per cycle.
- `done` asserts in the cycle after the handshake carrying `tw_last`, and `busy` drops in the following cycle.
- When `tw_ready` is low, `tw_data` is held stable while `tw_valid` is high.

## Configuration
- `TWIDDLE_CONJ_EN` defined: the output carries conj(W).
  - The imag field (low `DATA_WIDTH` bits) is two's-complement negated at FIFO write.
  - The most-negative imag value saturates to the most-positive value (0x8000 → 0x7FFF). This mode is used for IFFT.
  - Latency is unchanged.
- `TWIDDLE_CONJ_EN` undefined: ROM words pass through bit-exact.

## Structure
- `parameters.vh`: add `TW_ADDR_WIDTH` (4) and `FFT_LOG2N` (5) next to the existing `DATA_WIDTH`. FSM state encodings stay local to the block.
- One sub-module, `twiddle_fifo`: a synchronous FIFO of width `2*DATA_WIDTH+4`, with push/pop/count outputs and cleared on `rst`.

## Test plan
- Reset: assert `rst` for 3 cycles mid-pattern → every output is 0 on the cycle after `rst` is sampled.
- Free-running (`tw_ready`=1), ROM model with 2-cycle latency:
  - `start` at cycle 0 → `tw_valid` first high at cycle 4; 80 consecutive beats.
  - Stage 0 addresses are 0..15; stage 1 addresses are 0,2,..,14 repeated twice; stage 4 addresses are all 0.
  - The first beat's `tw_data` equals the addr-0 word 0x0001_0000.
  - `tw_last` is on beat 80, and `done` is 1 cycle later.
- Back-pressure: drop `tw_ready` for 10 cycles after the 3rd beat → `rom_en` deasserts once credits reach 4, and the sequence resumes with no loss or duplication (scoreboard matches all 80 beats).
- Random `tw_ready` (50%) → the beat sequence equals the free-running case, and `tw_data` is stable whenever `tw_valid && !tw_ready`.
- Control boundaries:
  - A `start` pulsed while `busy` is ignored, so the frame length stays 80.
  - `rst` at beat 40 → idle next cycle; a fresh `start` replays from beat 1 (stage 0, addr 0).
- `TWIDDLE_CONJ_EN` defined:
  - ROM word 0x0002_0004 → `tw_data` 0x0002_FFFC.
  - Imag field 0x8000 → 0x7FFF.
  - Word 0x0001_0000 → unchanged.
